// File: rtl/adc_capture_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_sequencer_if
//  Purpose  : Control and datapath-strobe bundle between the start/stop
//             controller, the capture sequencer and the SIPO + RAM datapath.
//  Signals  : start, stop          - controller requests (levels)
//             adc_cs_n             - ADC chip select, active low
//             data_logging         - SIPO shift enable
//             ram_we, ram_addr     - RAM write strobe and address
//             busy, done           - burst status / completion pulse
//             sample_count         - samples written in current/last burst
//             wrapped              - ring capture wrapped the address
//  Modports : master (controller/testbench side), slave (sequencer side)
//  Revision : 1.0  initial release
// ============================================================================
interface adc_capture_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              stop;
    logic              adc_cs_n;
    logic              data_logging;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   sample_count;
    logic              wrapped;

    modport master (
        output start, stop,
        input  adc_cs_n, data_logging, ram_we, ram_addr,
               busy, done, sample_count, wrapped
    );

    modport slave (
        input  start, stop,
        output adc_cs_n, data_logging, ram_we, ram_addr,
               busy, done, sample_count, wrapped
    );
endinterface
`default_nettype wire

// File: rtl/adc_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_sequencer
//  Purpose  : Sequences one serial-ADC capture channel. A start request runs
//             a timed burst of conversions: chip select low for CS_SETUP
//             cycles, SAMPLE_BITS cycles of SIPO shifting, a one-cycle RAM
//             write, then CS_HIGH quiet cycles, repeated per sample.
//  Ports    : clk      - sequencer clock (spi_clk)
//             reset_b  - asynchronous active-low reset
//             bus      - adc_capture_sequencer_if.slave (start/stop in;
//                        cs, shift enable, RAM strobe/address, status out)
//  Config   : CAPTURE_RING_EN - when defined, continuous ring capture until
//             stop; address wraps and 'wrapped' flags the first wrap.
//             When undefined, a burst ends after NUM_SAMPLES samples.
//  Revision : 1.0  initial release
// ============================================================================
module adc_capture_sequencer #(
    parameter int SAMPLE_BITS = 10,
    parameter int ADDR_W      = 4,
    parameter int NUM_SAMPLES = 16,
    parameter int CS_SETUP    = 2,
    parameter int CS_HIGH     = 3
) (
    input  wire                         clk,
    input  wire                         reset_b,
    adc_capture_sequencer_if.slave      bus
);

    localparam int C_MAX_A = (CS_SETUP > SAMPLE_BITS) ? CS_SETUP : SAMPLE_BITS;
    localparam int C_MAX   = (C_MAX_A > CS_HIGH) ? C_MAX_A : CS_HIGH;
    localparam int CNT_W   = $clog2(C_MAX + 1);

    localparam logic [CNT_W-1:0]  C_SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0]  C_SHIFT_LAST = CNT_W'(SAMPLE_BITS - 1);
    localparam logic [CNT_W-1:0]  C_GAP_LAST   = CNT_W'(CS_HIGH - 1);
    localparam logic [ADDR_W:0]   C_COUNT_SAT  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_stop_seen;
    logic              r_cs_n;
    logic              r_data_logging;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   r_sample_count;
    logic              w_burst_end;

`ifdef CAPTURE_RING_EN
    logic              r_wrapped;
    // Ring capture only ends on a stop request (latched or arriving now).
    assign w_burst_end = r_stop_seen || bus.stop;
    assign bus.wrapped = r_wrapped;
`else
    localparam logic [ADDR_W:0] C_NUM = (ADDR_W+1)'(NUM_SAMPLES);
    // sample_count has already been incremented by the WRITE state here.
    assign w_burst_end = r_stop_seen || bus.stop || (r_sample_count == C_NUM);
    assign bus.wrapped = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_stop_seen    <= 1'b0;
            r_cs_n         <= 1'b1;
            r_data_logging <= 1'b0;
            r_ram_we       <= 1'b0;
            r_ram_addr     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sample_count <= '0;
`ifdef CAPTURE_RING_EN
            r_wrapped      <= 1'b0;
`endif
        end else begin
            // Stop is sticky for the rest of the burst; it never cuts a
            // sample short, it only prevents the next SETUP.
            if (r_state != S_IDLE && bus.stop) begin
                r_stop_seen <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_stop_seen <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        r_state        <= S_SETUP;
                        r_cnt          <= '0;
                        r_cs_n         <= 1'b0;
                        r_busy         <= 1'b1;
                        r_ram_addr     <= '0;
                        r_sample_count <= '0;
`ifdef CAPTURE_RING_EN
                        r_wrapped      <= 1'b0;
`endif
                    end
                end

                S_SETUP: begin
                    if (r_cnt == C_SETUP_LAST) begin
                        r_state        <= S_SHIFT;
                        r_cnt          <= '0;
                        r_data_logging <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (r_cnt == C_SHIFT_LAST) begin
                        r_state        <= S_WRITE;
                        r_cnt          <= '0;
                        r_data_logging <= 1'b0;
                        r_ram_we       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WRITE: begin
                    r_state    <= S_GAP;
                    r_ram_we   <= 1'b0;
                    r_cs_n     <= 1'b1;
                    r_ram_addr <= r_ram_addr + 1'b1;
                    if (r_sample_count != C_COUNT_SAT) begin
                        r_sample_count <= r_sample_count + 1'b1;
                    end
`ifdef CAPTURE_RING_EN
                    if (r_ram_addr == {ADDR_W{1'b1}}) begin
                        r_wrapped <= 1'b1;
                    end
`endif
                end

                S_GAP: begin
                    if (r_cnt == C_GAP_LAST) begin
                        r_cnt <= '0;
                        if (w_burst_end) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SETUP;
                            r_cs_n  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state        <= S_IDLE;
                    r_cnt          <= '0;
                    r_cs_n         <= 1'b1;
                    r_data_logging <= 1'b0;
                    r_ram_we       <= 1'b0;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adc_cs_n     = r_cs_n;
    assign bus.data_logging = r_data_logging;
    assign bus.ram_we       = r_ram_we;
    assign bus.ram_addr     = r_ram_addr;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.sample_count = r_sample_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_capture_sequencer
//  Purpose  : Directed self-checking bench for adc_capture_sequencer at
//             default parameters (16-cycle sample period, first write 12
//             cycles after start is accepted, DONE 4 cycles after last write).
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_capture_sequencer;

    logic clk;
    logic reset_b;
    int   cyc;
    int   checks;
    int   failures;

    adc_capture_sequencer_if #(.ADDR_W(4)) bus ();

    adc_capture_sequencer #(
        .SAMPLE_BITS (10),
        .ADDR_W      (4),
        .NUM_SAMPLES (16),
        .CS_SETUP    (2),
        .CS_HIGH     (3)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-event log collected on the falling edge.
    int wr_addr[$];
    int wr_cyc[$];
    int wr_dl[$];
    int wr_wrap[$];
    int done_cnt;
    int done_cyc;
    int viol;
    int dl_run;

    always @(negedge clk) begin
        if (!reset_b) begin
            dl_run = 0;
        end else begin
            if (bus.ram_we) begin
                wr_addr.push_back(int'(bus.ram_addr));
                wr_cyc.push_back(cyc);
                wr_dl.push_back(dl_run);
                wr_wrap.push_back(int'(bus.wrapped));
                if (bus.data_logging || bus.adc_cs_n) viol++;
                dl_run = 0;
            end else if (bus.data_logging) begin
                dl_run++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_cyc.delete();
        wr_dl.delete();
        wr_wrap.delete();
        done_cnt = 0;
        done_cyc = -1;
        viol     = 0;
    endtask

    // Pulse start for one cycle; returns the cycle number seen at the
    // falling edge right after the accepting rising edge.
    task automatic pulse_start(output int c0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!bus.done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1);
        @(negedge clk);
    endtask

    // Expected write n at address n mod 16, cycle c0+12+16n, 10 shift cycles.
    task automatic check_writes(input int n_exp, input int c0);
        check("n_writes", wr_addr.size(), n_exp);
        for (int i = 0; i < wr_addr.size() && i < n_exp; i++) begin
            check($sformatf("addr[%0d]", i), wr_addr[i], i % 16);
            check($sformatf("shift_len[%0d]", i), wr_dl[i], 10);
            check($sformatf("wr_cycle[%0d]", i), wr_cyc[i], c0 + 12 + 16 * i);
        end
        check("we_cs_dl_rule", viol, 0);
    endtask

    int c0;

    initial begin
        checks   = 0;
        failures = 0;
        dl_run   = 0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        reset_b   = 1'b0;
        clear_log();

        // 1: reset state, held 5 cycles with start asserted
        bus.start = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_cs_n", bus.adc_cs_n, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_dl", bus.data_logging, 0);
        check("rst_count", bus.sample_count, 0);
        check("rst_wrapped", bus.wrapped, 0);
        check("rst_no_writes", wr_addr.size(), 0);
        bus.start = 1'b0;
        reset_b   = 1'b1;
        repeat (2) @(negedge clk);

`ifndef CAPTURE_RING_EN
        // 2: full burst
        clear_log();
        pulse_start(c0);
        check("busy_after_start", bus.busy, 1);
        check("cs_after_start", bus.adc_cs_n, 0);
        wait_done(400);
        check_writes(16, c0);
        check("done_once", done_cnt, 1);
        check("done_cycle", done_cyc, c0 + 256);
        check("count_16", bus.sample_count, 16);
        check("busy_after_done", bus.busy, 0);
        check("cs_idle", bus.adc_cs_n, 1);
        check("addr_hold", bus.ram_addr, 0);
        check("wrapped_tied0", bus.wrapped, 0);
        repeat (3) @(negedge clk);
`endif

        // 3: stop during sample 3 shift
        clear_log();
        pulse_start(c0);
        wait_until(c0 + 55);
        check("s3_shifting", bus.data_logging, 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        wait_done(200);
        check_writes(4, c0);
        check("stop_done_once", done_cnt, 1);
        check("stop_done_cycle", done_cyc, c0 + 64);
        check("stop_count", bus.sample_count, 4);
        check("stop_addr", bus.ram_addr, 4);
        check("stop_busy", bus.busy, 0);
        repeat (3) @(negedge clk);

        // 4a: start and stop together in IDLE
        clear_log();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("ss_busy", bus.busy, 0);
        check("ss_cs_n", bus.adc_cs_n, 1);
        check("ss_count_held", bus.sample_count, 4);
        repeat (3) @(negedge clk);
        check("ss_no_writes", wr_addr.size(), 0);

        // 4b: start during a burst is ignored (stop ends it after sample 2)
        clear_log();
        pulse_start(c0);
        wait_until(c0 + 20);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(c0 + 36);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        wait_done(200);
        check_writes(3, c0);
        check("restart_count", bus.sample_count, 3);

        // 5: reset during SHIFT
        clear_log();
        repeat (2) @(negedge clk);
        pulse_start(c0);
        wait_until(c0 + 5);
        check("pre_rst_dl", bus.data_logging, 1);
        reset_b = 1'b0;
        #1;
        check("arst_cs_n", bus.adc_cs_n, 1);
        check("arst_dl", bus.data_logging, 0);
        check("arst_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_writes", wr_addr.size(), 0);
        clear_log();
        pulse_start(c0);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        wait_done(100);
        check_writes(1, c0);
        check("restart_count1", bus.sample_count, 1);

`ifdef CAPTURE_RING_EN
        // 6: ring capture of 20 samples
        clear_log();
        repeat (2) @(negedge clk);
        pulse_start(c0);
        wait_until(c0 + 310);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        wait_done(100);
        check_writes(20, c0);
        if (wr_wrap.size() >= 17) begin
            check("wrap_before", wr_wrap[15], 0);
            check("wrap_at_17th", wr_wrap[16], 1);
        end
        check("ring_count_sat", bus.sample_count, 16);
        check("ring_wrapped", bus.wrapped, 1);
        check("ring_addr", bus.ram_addr, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
